// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32I constants, fetch FSM encoding and fetch-buffer entry type
package rv32_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RV32_NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
    typedef enum logic [1:0] {S_BOOT, S_FETCH, S_HOLD} fetch_state_e;
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_buf_rv32.sv
// fetch_buf_rv32: synchronous FIFO of {instr, pc} with flush; empty head reads as a NOP at PC 0
module fetch_buf_rv32
    import rv32_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic                             iCLK,
    input  logic                             iRSTn,
    input  logic                             push_i,
    input  fetch_entry_t                     entry_i,
    input  logic                             pop_i,
    input  logic                             flush_i,
    output logic [$clog2(BUF_DEPTH):0]       count_o,
    output fetch_entry_t                     head_o
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;
    fetch_entry_t mem_q [BUF_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic do_pop;
    assign do_pop = pop_i && cnt_q != '0;
    assign count_o = cnt_q;
    assign head_o = cnt_q == '0 ? {RV32_NOP, {XLEN{1'b0}}} : mem_q[rd_q];
    always_ff @(posedge iCLK) begin
        if (!iRSTn || flush_i) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= entry_i;
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(push_i) - CW'(do_pop);
        end
    end
    always_ff @(posedge iCLK) begin
        if (iRSTn && !flush_i && push_i && !do_pop) assert (cnt_q != CW'(BUF_DEPTH));
    end
endmodule

// File: rtl/fetch_rv32.sv
// fetch_rv32: RV32I fetch unit driving the I-cache, replaying stalled words and flushing on redirect
module fetch_rv32
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            iCLK,
    input  logic            iRSTn,
    output logic [XLEN-1:0] oPCADDR,
    input  logic [XLEN-1:0] iPCDATA,
    input  logic            iStallI,
    input  logic            iREDIRECT,
    input  logic [XLEN-1:0] iREDIRECT_PC,
    output logic [XLEN-1:0] oINSTR,
    output logic [XLEN-1:0] oINSTR_PC,
    output logic            oVALID,
    input  logic            iREADY
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam logic [XLEN-1:0] BOOT_PC = RESET_PC & ~XLEN'(3);
    fetch_state_e state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, inflight_pc_q, inflight_pc_d;
    logic inflight_q, inflight_d;
    logic [CW-1:0] count;
    fetch_entry_t head;
    logic pop, push, replay, room, issue;
    assign oVALID = count != '0;
    assign pop = oVALID & iREADY;
    assign push = inflight_q & ~iStallI & ~iREDIRECT;
    assign replay = inflight_q & iStallI;
    assign room = count + CW'(inflight_q) < CW'(BUF_DEPTH) + CW'(pop);
    assign issue = state_q == S_FETCH && room && !replay && !iREDIRECT;
    always_comb begin
        state_d = (iREDIRECT || state_q == S_BOOT || room) ? S_FETCH : S_HOLD;
        pc_d = iREDIRECT ? (iREDIRECT_PC & ~XLEN'(3)) : replay ? inflight_pc_q : issue ? pc_q + XLEN'(4) : pc_q;
        inflight_d = issue;
        inflight_pc_d = issue ? pc_q : inflight_pc_q;
    end
    always_ff @(posedge iCLK) begin
        if (!iRSTn) begin
            state_q <= S_BOOT;
            pc_q <= BOOT_PC;
            inflight_q <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            inflight_q <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end
    fetch_buf_rv32 #(.BUF_DEPTH(BUF_DEPTH)) u_buf (
        .iCLK    (iCLK),
        .iRSTn   (iRSTn),
        .push_i  (push),
        .entry_i ({iPCDATA, inflight_pc_q}),
        .pop_i   (pop),
        .flush_i (iREDIRECT),
        .count_o (count),
        .head_o  (head)
    );
    assign oPCADDR = pc_q;
    assign oINSTR = head.instr;
    assign oINSTR_PC = head.pc;
endmodule

// File: tb/tb_fetch_rv32.sv
// tb_fetch_rv32: table-driven and directed checks of fetch_rv32 against a word-addressed I-cache model
module tb_fetch_rv32;
    logic clk = 1'b0, rstn = 1'b0, stall = 1'b0, ready = 1'b1, redir = 1'b0;
    logic [31:0] redir_pc = '0, prev_addr = '0;
    logic [31:0] addr, pcdata, instr, ipc;
    logic valid;
    int checks = 0, failures = 0;
    typedef struct {
        logic        rstn, ready, redir;
        logic [31:0] rpc;
        logic        exp_v;
        logic [31:0] exp_addr, exp_ipc;
        logic        chk_head;
    } vec_t;
    vec_t tbl [20];
    always #5 clk = ~clk;
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction
    always @(posedge clk) prev_addr <= addr;
    assign pcdata = memf(prev_addr);
    fetch_rv32 #(.RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
        .iCLK(clk), .iRSTn(rstn), .oPCADDR(addr), .iPCDATA(pcdata), .iStallI(stall),
        .iREDIRECT(redir), .iREDIRECT_PC(redir_pc), .oINSTR(instr), .oINSTR_PC(ipc),
        .oVALID(valid), .iREADY(ready)
    );
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    function automatic vec_t v(input logic r, input logic rd, input logic rq, input logic [31:0] rp,
                               input logic ev, input logic [31:0] ea, input logic [31:0] ei, input logic ch);
        vec_t x;
        x.rstn = r; x.ready = rd; x.redir = rq; x.rpc = rp;
        x.exp_v = ev; x.exp_addr = ea; x.exp_ipc = ei; x.chk_head = ch;
        return x;
    endfunction
    initial begin
        int exp_pc, stall_left, n8;
        logic seen8;
        tbl[0]  = v(0, 1, 0, 0,     0, 32'h000, 0,       1);
        tbl[1]  = v(0, 1, 0, 0,     0, 32'h000, 0,       1);
        tbl[2]  = v(1, 1, 0, 0,     0, 32'h000, 0,       0);
        tbl[3]  = v(1, 1, 0, 0,     0, 32'h004, 0,       0);
        tbl[4]  = v(1, 1, 0, 0,     1, 32'h008, 32'h000, 0);
        tbl[5]  = v(1, 1, 0, 0,     1, 32'h00C, 32'h004, 0);
        tbl[6]  = v(1, 1, 0, 0,     1, 32'h010, 32'h008, 0);
        tbl[7]  = v(1, 0, 1, 32'h103, 0, 32'h100, 0,     0);
        tbl[8]  = v(1, 1, 0, 0,     0, 32'h104, 0,       0);
        tbl[9]  = v(1, 1, 0, 0,     1, 32'h108, 32'h100, 0);
        tbl[10] = v(1, 1, 0, 0,     1, 32'h10C, 32'h104, 0);
        tbl[11] = v(1, 0, 0, 0,     1, 32'h10C, 32'h104, 0);
        tbl[12] = v(1, 0, 0, 0,     1, 32'h10C, 32'h104, 0);
        tbl[13] = v(1, 0, 0, 0,     1, 32'h10C, 32'h104, 0);
        tbl[14] = v(1, 0, 0, 0,     1, 32'h10C, 32'h104, 0);
        tbl[15] = v(1, 0, 0, 0,     1, 32'h10C, 32'h104, 0);
        tbl[16] = v(1, 1, 0, 0,     1, 32'h10C, 32'h108, 0);
        tbl[17] = v(1, 1, 0, 0,     0, 32'h110, 0,       0);
        tbl[18] = v(1, 1, 0, 0,     1, 32'h114, 32'h10C, 0);
        tbl[19] = v(1, 1, 0, 0,     1, 32'h118, 32'h110, 0);
        for (int i = 0; i < 20; i++) begin
            rstn = tbl[i].rstn; ready = tbl[i].ready; redir = tbl[i].redir; redir_pc = tbl[i].rpc;
            step();
            check($sformatf("t%0d valid", i), 32'(valid), 32'(tbl[i].exp_v));
            check($sformatf("t%0d pcaddr", i), addr, tbl[i].exp_addr);
            if (tbl[i].exp_v) begin
                check($sformatf("t%0d instr_pc", i), ipc, tbl[i].exp_ipc);
                check($sformatf("t%0d instr", i), instr, memf(tbl[i].exp_ipc));
            end
            if (tbl[i].chk_head) begin
                check($sformatf("t%0d reset_instr", i), instr, 32'h0000_0013);
                check($sformatf("t%0d reset_pc", i), ipc, 32'h0);
            end
        end
        redir = 1'b0; ready = 1'b1; rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
        exp_pc = 0; stall_left = 0; n8 = 0; seen8 = 1'b0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (valid) begin
                check("stall_stream_pc", ipc, 32'(exp_pc));
                check("stall_stream_instr", instr, memf(32'(exp_pc)));
                exp_pc += 4;
            end
            if (addr == 32'h8) n8++;
            stall = stall_left > 0;
            if (stall_left > 0) stall_left--;
            if (addr == 32'h8 && !seen8) begin
                seen8 = 1'b1;
                stall_left = 3;
            end
        end
        check("stall_replays_of_8", 32'(n8), 32'd3);
        check("stall_progress", 32'(exp_pc >= 32'h40), 32'd1);
        stall = 1'b0; redir = 1'b1; redir_pc = 32'hFFFF_FFFF;
        step();
        redir = 1'b0;
        check("wrap_redirect_addr", addr, 32'hFFFF_FFFC);
        check("wrap_flush_valid", 32'(valid), 32'd0);
        step();
        check("wrap_next_addr", addr, 32'h0);
        step();
        check("wrap_head_valid", 32'(valid), 32'd1);
        check("wrap_head_pc", ipc, 32'hFFFF_FFFC);
        check("wrap_head_instr", instr, memf(32'hFFFF_FFFC));
        step();
        check("wrap_after_pc", ipc, 32'h0);
        check("wrap_after_instr", instr, memf(32'h0));
        stall = 1'b1; rstn = 1'b0;
        step();
        check("rst_stall_valid", 32'(valid), 32'd0);
        check("rst_stall_addr", addr, 32'h0);
        check("rst_stall_instr", instr, 32'h0000_0013);
        check("rst_stall_pc", ipc, 32'h0);
        stall = 1'b0; rstn = 1'b1; ready = 1'b0;
        for (int c = 0; c < 4; c++) step();
        check("fill_valid", 32'(valid), 32'd1);
        check("fill_head_pc", ipc, 32'h0);
        check("fill_hold_addr", addr, 32'h8);
        rstn = 1'b0;
        step();
        check("rst_full_valid", 32'(valid), 32'd0);
        check("rst_full_addr", addr, 32'h0);
        check("rst_full_instr", instr, 32'h0000_0013);
        rstn = 1'b1; ready = 1'b1;
        step();
        check("rel_boot_valid", 32'(valid), 32'd0);
        step();
        check("rel_issue_addr", addr, 32'h4);
        step();
        check("rel_first_valid", 32'(valid), 32'd1);
        check("rel_first_pc", ipc, 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
